data_mem_arbiter: RTL
=====================

Name: data_mem_arbiter

Overview:
- Shares the single-port 128-byte, word-addressed data memory between two requesters: m0 (CPU load/store stage) and m1 (DMA/debug loader).
- Arbitrates round-robin, drives the memory's address/MemWrite/MemRead/WriteData pins from registers, and captures ReadData.
- Returns one `done` pulse per transaction to the granted requester.
- Sits between the requesters and the data memory instance. The memory writes on posedge and updates ReadData on negedge.

Parameters:
- ADDR_W, 7, byte-address width; must match the memory address port.
- DATA_W, 32, data word width.
- CHECK_ALIGN, 1, when 1, reject addresses with addr[1:0] != 0.

Ports:
- clock  in  1  single system clock; all state on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- m0_req  in  1  m0 request; held high with its fields stable until m0_done.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  m0 byte address.
- m0_wdata  in  DATA_W  m0 write data.
- m0_gnt  out  1  high while m0 owns the memory (ACCESS and RESP).
- m0_done  out  1  one-cycle completion pulse.
- m0_err  out  1  misalignment flag; valid with m0_done.
- m0_rdata  out  DATA_W  read result; valid with m0_done and held until the next m0 read completes.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_done, m1_err, m1_rdata: identical to the m0 ports.
- mem_address  out  ADDR_W  to memory address.
- mem_write  out  1  to MemWrite.
- mem_read  out  1  to MemRead.
- mem_wdata  out  DATA_W  to WriteData.
- mem_rdata  in  DATA_W  from ReadData.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; last_grant=1, so m0 wins the first tie.
  - All gnt/done/err = 0; mem_write = mem_read = 0; mem_address = 0; mem_wdata = 0; both rdata = 0.
- FSM, states IDLE -> ACCESS -> RESP -> IDLE; one transaction every 3 cycles at most.
- IDLE:
  - Sample the requests at posedge.
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_grant, then update last_grant.
  - Neither high: stay in IDLE.
  - On a grant, register the winner's addr/we/wdata into the mem_* outputs, set that requester's gnt, and go to ACCESS.
- ACCESS (1 cycle):
  - mem_write = we and mem_read = !we, unless the access is misaligned (CHECK_ALIGN=1 and addr[1:0] != 0). A misaligned access asserts neither strobe.
  - Memory writes at the posedge that ends ACCESS.
  - For reads, ReadData updates at the negedge inside ACCESS. The arbiter latches mem_rdata into the winner's rdata at the posedge that ends ACCESS. A misaligned read latches 0.
  - Go to RESP.
- RESP (1 cycle):
  - Strobes are 0; winner's done = 1; err = misaligned; gnt stays high.
  - The loser's outputs are unchanged.
  - Go to IDLE and clear gnt.
- Latency: request sampled at edge N -> memory strobe during cycle N+1 -> done during cycle N+2.
- A request still high at the IDLE sampling edge after RESP is treated as a new transaction. Requesters drop req on the edge where they see done.
- Dropping req during ACCESS or RESP has no effect; the transaction completes.
- No other requester is granted while gnt is high. At most one gnt is high at any time.
- Strobes are never high outside ACCESS, and mem_write and mem_read are never both high.
- Reset mid-ACCESS: strobes drop immediately, so no write occurs at the next edge; done is not issued; the FSM restarts in IDLE.
- Address bits are passed through unmodified; the memory does its own word indexing with address[6:2].

Test Plan:
- m0 write addr 0x08, data 0xDEADBEEF, then m0 read 0x08 -> mem_write high for exactly 1 cycle; m0_done 2 cycles after the req edge; m0_rdata=0xDEADBEEF, m0_err=0.
- m0 and m1 both request from reset, repeated for 4 transactions -> grant order m0, m1, m0, m1; gnt never high for both.
- m1 alone requests continuously, back-to-back reads -> one done every 3 cycles; m0_gnt stays 0; m0 outputs unchanged.
- m0 read at addr 0x05 with CHECK_ALIGN=1 -> no mem_read/mem_write pulse; m0_done=1, m0_err=1, m0_rdata=0; memory contents unchanged.
- m1 write to 0x10 in progress; reset_n pulsed low during ACCESS -> all outputs zero at once; a later read of 0x10 returns the old value; the first post-reset tie goes to m0.
- m0 drops req during ACCESS -> transaction still completes with m0_done=1; no new grant to m0 in the next IDLE.

Source files
------------

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter that shares a single-port, word-addressed data memory between
// the CPU load/store stage (m0) and a DMA/debug loader (m1); one transaction per three cycles.
module data_mem_arbiter #(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int CHECK_ALIGN = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_write,
  output logic              mem_read,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  // Handshake: a requester raises req with stable fields and holds them until it
  // sees its one-cycle done; gnt marks ownership from ACCESS through RESP.

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_owner;
  logic                r_we;
  logic                r_mis;
  logic [1:0]          r_gnt;
  logic [1:0]          r_done;
  logic [1:0]          r_err;
  logic                r_write;
  logic                r_read;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_rdata0;
  logic [DATA_W-1:0]   r_rdata1;

  logic                w_any;
  logic                w_winner;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_sel_mis;
  logic [DATA_W-1:0]   w_rd_val;

  logic                w_nxt_last;
  logic                w_nxt_owner;
  logic                w_nxt_we;
  logic                w_nxt_mis;
  logic [1:0]          w_nxt_gnt;
  logic [1:0]          w_nxt_done;
  logic [1:0]          w_nxt_err;
  logic                w_nxt_write;
  logic                w_nxt_read;
  logic [ADDR_W-1:0]   w_nxt_addr;
  logic [DATA_W-1:0]   w_nxt_wdata;
  logic [DATA_W-1:0]   w_nxt_rdata0;
  logic [DATA_W-1:0]   w_nxt_rdata1;

  // A tie goes to whoever was not granted last; a lone request simply wins.
  assign w_any       = m0_req | m1_req;
  assign w_winner    = (m0_req & m1_req) ? ~r_last_grant : m1_req;
  assign w_sel_we    = w_winner ? m1_we    : m0_we;
  assign w_sel_addr  = w_winner ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_winner ? m1_wdata : m0_wdata;
  assign w_sel_mis   = (CHECK_ALIGN != 0) && (w_sel_addr[1:0] != 2'b00);
  assign w_rd_val    = r_mis ? '0 : mem_rdata;

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_we         <= 1'b0;
      r_mis        <= 1'b0;
      r_gnt        <= 2'b00;
      r_done       <= 2'b00;
      r_err        <= 2'b00;
      r_write      <= 1'b0;
      r_read       <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_nxt_last;
      r_owner      <= w_nxt_owner;
      r_we         <= w_nxt_we;
      r_mis        <= w_nxt_mis;
      r_gnt        <= w_nxt_gnt;
      r_done       <= w_nxt_done;
      r_err        <= w_nxt_err;
      r_write      <= w_nxt_write;
      r_read       <= w_nxt_read;
      r_addr       <= w_nxt_addr;
      r_wdata      <= w_nxt_wdata;
      r_rdata0     <= w_nxt_rdata0;
      r_rdata1     <= w_nxt_rdata1;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = w_any ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered output
  always_comb begin
    w_nxt_last   = r_last_grant;
    w_nxt_owner  = r_owner;
    w_nxt_we     = r_we;
    w_nxt_mis    = r_mis;
    w_nxt_gnt    = r_gnt;
    w_nxt_done   = 2'b00;
    w_nxt_err    = r_err;
    w_nxt_write  = 1'b0;
    w_nxt_read   = 1'b0;
    w_nxt_addr   = r_addr;
    w_nxt_wdata  = r_wdata;
    w_nxt_rdata0 = r_rdata0;
    w_nxt_rdata1 = r_rdata1;
    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_nxt_last  = w_winner;
          w_nxt_owner = w_winner;
          w_nxt_we    = w_sel_we;
          w_nxt_mis   = w_sel_mis;
          w_nxt_addr  = w_sel_addr;
          w_nxt_wdata = w_sel_wdata;
          w_nxt_gnt   = w_winner ? 2'b10 : 2'b01;
          w_nxt_write = w_sel_we & ~w_sel_mis;
          w_nxt_read  = ~w_sel_we & ~w_sel_mis;
        end
      end
      S_ACCESS: begin
        // ReadData settled at the negedge inside ACCESS; capture it now.
        w_nxt_done[r_owner] = 1'b1;
        w_nxt_err[r_owner]  = r_mis;
        if (!r_we) begin
          if (r_owner) w_nxt_rdata1 = w_rd_val;
          else         w_nxt_rdata0 = w_rd_val;
        end
      end
      S_RESP: begin
        w_nxt_gnt = 2'b00;
        w_nxt_err = 2'b00;
      end
      default: ;
    endcase
  end

  assign m0_gnt      = r_gnt[0];
  assign m1_gnt      = r_gnt[1];
  assign m0_done     = r_done[0];
  assign m1_done     = r_done[1];
  assign m0_err      = r_err[0];
  assign m1_err      = r_err[1];
  assign m0_rdata    = r_rdata0;
  assign m1_rdata    = r_rdata1;
  assign mem_address = r_addr;
  assign mem_write   = r_write;
  assign mem_read    = r_read;
  assign mem_wdata   = r_wdata;
  assign dbg_state   = r_state;

endmodule
